montgomery_param: RTL

MONTGOMERY_PARAM -- requirements
Module: montgomery_param

---
 rtl/montgomery_pkg.sv | 17 +
 rtl/montgomery_final_sub.sv | 22 ++
 rtl/montgomery_param.sv | 119 +++++++++++
 3 files changed

// File: rtl/montgomery_pkg.sv
// Shared definitions for the bit-serial Montgomery multiplier:
// FSM encoding, default width and operating-mode codes.
package montgomery_pkg;

  localparam int DEFAULT_WIDTH = 512;

  localparam logic MODE_MUL = 1'b0;
  localparam logic MODE_SQR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOOP = 2'd1,
    ST_SUB  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/montgomery_final_sub.sv
// Conditional final subtraction: brings the loop accumulator C (< 2M for
// legal operands) into the fully reduced range [0, M).
module montgomery_final_sub
  import montgomery_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH+1:0] c,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] r
);

  logic [WIDTH+1:0] m_ext;
  logic             ge;

  always_comb begin
    m_ext = {2'b00, m};
    ge    = (c >= m_ext);
    r     = ge ? WIDTH'(c - m_ext) : WIDTH'(c);
  end

endmodule

// File: rtl/montgomery_param.sv
// Bit-serial radix-2 Montgomery multiplier: result = A*B*2^-WIDTH mod M,
// one multiplier bit per LOOP cycle, fixed latency of WIDTH+2 cycles.
module montgomery_param
  import montgomery_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit SQUARE_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_m,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             busy
);

  localparam int            CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [WIDTH+1:0]   c_q, c_d;
  logic [CW-1:0]      i_q, i_d;
  logic [WIDTH-1:0]   result_q, result_d;

  logic               mode_eff;
  logic [WIDTH+1:0]   s_sum;
  logic [WIDTH+2:0]   t_sum;
  logic [WIDTH+1:0]   c_loop;
  logic [WIDTH-1:0]   sub_r;

  assign mode_eff = SQUARE_EN ? mode : MODE_MUL;

  // a_q shifts right each iteration, so bit 0 is always a_i.
  always_comb begin
    s_sum  = c_q + (a_q[0] ? {2'b00, b_q} : '0);
    t_sum  = {1'b0, s_sum} + (s_sum[0] ? {3'b000, m_q} : '0);
    c_loop = (WIDTH+2)'(t_sum >> 1);
  end

  montgomery_final_sub #(
    .WIDTH (WIDTH)
  ) u_final_sub (
    .c (c_q),
    .m (m_q),
    .r (sub_r)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    m_d      = m_q;
    c_d      = c_q;
    i_d      = i_q;
    result_d = result_q;
    done     = 1'b0;
    busy     = (state_q != ST_IDLE);

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = in_a;
          b_d     = (mode_eff == MODE_SQR) ? in_a : in_b;
          m_d     = in_m;
          c_d     = '0;
          i_d     = '0;
          state_d = ST_LOOP;
        end
      end
      ST_LOOP: begin
        c_d = c_loop;
        a_d = a_q >> 1;
        i_d = i_q + CW'(1);
        if (i_q == LAST) begin
          state_d = ST_SUB;
        end
      end
      ST_SUB: begin
        result_d = sub_r;
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      m_q      <= '0;
      c_q      <= '0;
      i_q      <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      m_q      <= m_d;
      c_q      <= c_d;
      i_q      <= i_d;
      result_q <= result_d;
    end
  end

  assign result = result_q;

endmodule
